// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive/transmit blocks: register map,
// STATUS bit positions, engine state encoding and AXI response codes.
package spi_pkg;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_CLKDIV = 4'h4;
    localparam logic [3:0] REG_STATUS = 4'h8;
    localparam logic [3:0] REG_RXDATA = 4'hC;

    localparam int CTRL_START     = 0;
    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_OVERRUN = 2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    // A divider of zero would stall the engine, so it runs as one.
    function automatic logic [15:0] half_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/spi_miso_rx_if.sv
// AXI4-Lite slave bus bundle for the SPI receiver register file.
interface spi_miso_rx_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    // A transfer on any channel completes on the rising edge where its
    // VALID and READY are both high; VALID, once raised, holds until then.
    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

endinterface

// File: rtl/spi_miso_rx_engine.sv
// SPI mode-0 receive engine: chip-select sequencing, SCLK divider and the
// 32-bit MSB-first shift register.
module spi_rx_engine
    import spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] clkdiv,
    input  logic        miso,
    output logic        sclk,
    output logic        cs_n,
    output logic        busy,
    output logic        done_set,
    output logic [31:0] shift_data,
    output spi_state_t  state
);

    spi_state_t  state_q, state_d;
    logic [15:0] h_q;
    logic [15:0] div_cnt_q;
    logic [5:0]  edge_cnt_q;
    logic        sclk_q;
    logic [31:0] shift_q;
    logic        tick;
    logic        last_edge;

    assign tick      = (div_cnt_q == h_q - 16'd1);
    assign last_edge = (edge_cnt_q == 6'd63);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)             state_d = ST_SETUP;
            ST_SETUP: if (tick)              state_d = ST_SHIFT;
            ST_SHIFT: if (tick && last_edge) state_d = ST_HOLD;
            ST_HOLD:  if (tick)              state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cs_n     = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
        done_set = (state_q == ST_HOLD) && tick;
    end

    // Half period is frozen at START so register writes cannot bend timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q        <= 16'd1;
            div_cnt_q  <= 16'd0;
            edge_cnt_q <= 6'd0;
            sclk_q     <= 1'b0;
            shift_q    <= 32'd0;
        end else if (state_q == ST_IDLE) begin
            div_cnt_q  <= 16'd0;
            edge_cnt_q <= 6'd0;
            sclk_q     <= 1'b0;
            if (start) begin
                h_q     <= half_period(clkdiv);
                shift_q <= 32'd0;
            end
        end else begin
            div_cnt_q <= tick ? 16'd0 : div_cnt_q + 16'd1;
            if (state_q == ST_SHIFT && tick) begin
                sclk_q     <= ~sclk_q;
                edge_cnt_q <= edge_cnt_q + 6'd1;
                if (!sclk_q) shift_q <= {shift_q[30:0], miso};
            end
        end
    end

    assign sclk       = sclk_q;
    assign shift_data = shift_q;
    assign state      = state_q;

endmodule

// File: rtl/spi_miso_rx.sv
// AXI4-Lite register front end for the SPI MISO receiver: CTRL, CLKDIV,
// STATUS and RXDATA around one spi_rx_engine.
module spi_miso_rx
    import spi_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [15:0] CLKDIV_RESET       = 16'd4
) (
    input  logic         ACLK,
    input  logic         ARESET,
    spi_miso_rx_if.slave s_axi,
    output logic         SPI_SCLK,
    output logic         SPI_CS_N,
    input  logic         SPI_MISO,
    output spi_state_t   dbg_state
);

    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
    logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata;
    logic [3:0]                    wstrb;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
    logic                          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic                          wr_en, rd_en, start;
    logic [15:0]                   clkdiv_q;
    logic [31:0]                   rxdata_q;
    logic                          done_q, overrun_q;
    logic                          busy, done_set;
    logic [31:0]                   shift_data;
    logic                          unused;

    assign awaddr = s_axi.S_AXI_AWADDR;
    assign araddr = s_axi.S_AXI_ARADDR;
    assign wdata  = s_axi.S_AXI_WDATA;
    assign wstrb  = s_axi.S_AXI_WSTRB;
    assign unused = ^{wdata[31:16], wstrb[3:2]};

    assign wr_en = awready_q & wready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    assign rd_en = arready_q & s_axi.S_AXI_ARVALID;
    assign start = wr_en && (awaddr == C_S_AXI_ADDR_WIDTH'(REG_CTRL))
                   && wstrb[0] && wdata[CTRL_START];

    spi_rx_engine u_engine (
        .clk        (ACLK),
        .rst        (ARESET),
        .start      (start),
        .clkdiv     (clkdiv_q),
        .miso       (SPI_MISO),
        .sclk       (SPI_SCLK),
        .cs_n       (SPI_CS_N),
        .busy       (busy),
        .done_set   (done_set),
        .shift_data (shift_data),
        .state      (dbg_state)
    );

    always_comb begin
        rd_mux = '0;
        if (araddr == C_S_AXI_ADDR_WIDTH'(REG_CLKDIV)) begin
            rd_mux[15:0] = clkdiv_q;
        end else if (araddr == C_S_AXI_ADDR_WIDTH'(REG_STATUS)) begin
            rd_mux[STATUS_BUSY]    = busy;
            rd_mux[STATUS_DONE]    = done_q;
            rd_mux[STATUS_OVERRUN] = overrun_q;
        end else if (araddr == C_S_AXI_ADDR_WIDTH'(REG_RXDATA)) begin
            rd_mux = rxdata_q;
        end
    end

    // READY is withheld while a response is pending, so each request gets
    // exactly one single-cycle READY pulse and one response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid_q && !awready_q;
            wready_q  <= s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid_q && !awready_q;
            if (wr_en)                          bvalid_q <= 1'b1;
            else if (s_axi.S_AXI_BREADY)        bvalid_q <= 1'b0;
            arready_q <= s_axi.S_AXI_ARVALID && !rvalid_q && !arready_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (s_axi.S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            clkdiv_q  <= CLKDIV_RESET;
            rxdata_q  <= 32'd0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en && awaddr == C_S_AXI_ADDR_WIDTH'(REG_CLKDIV)) begin
                if (wstrb[0]) clkdiv_q[7:0]  <= wdata[7:0];
                if (wstrb[1]) clkdiv_q[15:8] <= wdata[15:8];
            end
            // Completion events take priority over the software clears.
            if (done_set) begin
                rxdata_q <= shift_data;
                done_q   <= 1'b1;
            end else if (rd_en && araddr == C_S_AXI_ADDR_WIDTH'(REG_RXDATA)) begin
                done_q <= 1'b0;
            end
            if (done_set && done_q) begin
                overrun_q <= 1'b1;
            end else if (wr_en && awaddr == C_S_AXI_ADDR_WIDTH'(REG_STATUS)
                         && wstrb[0] && wdata[STATUS_OVERRUN]) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = RESP_OKAY;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: doc/spi_miso_rx.md
SPI_MISO_RX -- requirements
Module: spi_miso_rx

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4, AXI4-Lite byte address width.
REQ-003 Parameter CLKDIV_RESET, default 16'd4, reset value of CLKDIV register.
REQ-004 ACLK  in  1  single clock; all logic on rising edge.
REQ-005 ARESET  in  1  synchronous, active-high reset.
REQ-006 S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  4/1/1  write address channel.
REQ-007 S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
REQ-008 S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
REQ-009 S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  4/1/1  read address channel.
REQ-010 S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
REQ-011 SPI_SCLK  out  1  serial clock, SPI mode 0 (idle low).
REQ-012 SPI_CS_N  out  1  chip select, active low.
REQ-013 SPI_MISO  in  1  serial data from the device, MSB first; already synchronous to ACLK at the pin wrapper.

Function
REQ-014 Register map: 0x0 CTRL (bit0 START, write-1, self-clearing, reads 0); 0x4 CLKDIV[15:0] R/W; 0x8 STATUS (bit0 BUSY RO, bit1 DONE RO, bit2 OVERRUN W1C); 0xC RXDATA[31:0] RO.
REQ-015 Write: when AWVALID and WVALID are high and BVALID is low, AWREADY and WREADY pulse for exactly one cycle; BVALID rises the following cycle and holds until BREADY; BRESP = 2'b00 always.
REQ-016 Read: when ARVALID is high and RVALID is low, ARREADY pulses for one cycle; RVALID and RDATA are registered the following cycle and held stable until RREADY; RRESP = 2'b00 always.
REQ-017 WSTRB applies per byte to CLKDIV; writes to RO fields and to unused bits are ignored and still answered OKAY.
REQ-018 Half-period H = CLKDIV, with CLKDIV = 0 treated as 1; H is latched at START and is not affected by CLKDIV writes during a transfer.
REQ-019 FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
REQ-020 IDLE: CS_N = 1, SCLK = 0, BUSY = 0; a START write (WDATA[0]=1 with WSTRB[0]) moves the FSM to SETUP in the cycle after the write handshake.
REQ-021 SETUP: CS_N = 0 for H cycles, then SHIFT.
REQ-022 SHIFT: SCLK toggles every H cycles, giving 32 rising edges; on each rising edge MISO is sampled into shift[0] with a left shift; a 6-bit counter ends the state after the 32nd falling edge (64*H cycles).
REQ-023 HOLD: SCLK = 0, CS_N = 0 for H cycles; on exit CS_N = 1, RXDATA <= shift, DONE <= 1, and OVERRUN <= 1 if DONE was already 1.
REQ-024 CS_N is low for exactly 66*H cycles per transfer.
REQ-025 START while BUSY is ignored, with no side effects.
REQ-026 A read of RXDATA clears DONE; if DONE is set in the same cycle, the set wins.
REQ-027 An OVERRUN W1C write in the same cycle as an OVERRUN set: the set wins.

Reset
REQ-028 While ARESET is high: FSM to IDLE, CS_N = 1, SCLK = 0, all READY/VALID outputs = 0, RXDATA = 0, shift register = 0, DONE = 0, OVERRUN = 0, CLKDIV = CLKDIV_RESET.
REQ-029 Reset during a transfer aborts it immediately; no DONE is set and no partial data reaches RXDATA.

Structure
REQ-030 A shared package spi_pkg holds the register offsets, the STATUS bit indices, the FSM state enum and the RESP_OKAY constant; the SPI_MOSI transmitter shares the same package.
REQ-031 One sub-module, spi_rx_engine, contains the FSM, the clock divider and the shift register; the top level contains the AXI4-Lite slave logic and the register file.

Verification
REQ-032 Reset, then read all four registers -> 0x0, 0x4, 0x0, 0x0000_0000; every RRESP = 0.
REQ-033 CLKDIV = 2, START, MISO driven with 0xA5C3_0F96 -> CS_N low for 132 cycles, 32 SCLK pulses, STATUS = 0x2, RXDATA = 0xA5C3_0F96, then STATUS = 0x0 after the RXDATA read.
REQ-034 Two transfers (0x1234_5678, then 0xDEAD_BEEF) with no RXDATA read between them -> STATUS = 0x6 and RXDATA = 0xDEAD_BEEF; writing 0x4 to STATUS -> STATUS = 0x2.
REQ-035 CLKDIV = 0 -> H = 1 and CS_N low for 66 cycles; a CLKDIV = 8 write mid-transfer leaves the timing unchanged.
REQ-036 START written while BUSY -> exactly one transfer of 32 SCLK pulses.
REQ-037 ARESET asserted after the 10th SCLK rising edge -> CS_N = 1 and SCLK = 0 on the next cycle, STATUS = 0x0, RXDATA = 0.
REQ-038 Hold BREADY and RREADY low for 5 cycles -> BVALID, RVALID and RDATA stay stable, and no second handshake is accepted.
